// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared types and grant encodings for the Wishbone arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_tmo_cnt.sv
`default_nettype none
// ============================================================================
// Module      : wb_tmo_cnt
// Description : Transaction age counter with synchronous clear and expiry flag.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_tmo_cnt #(
    parameter int TMO_W   = 10,
    parameter int TMO_CYC = 1023
) (
    input  logic wbm_clk_i,
    input  logic wbm_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [TMO_W-1:0] c_LIMIT = TMO_W'(TMO_CYC);

    logic [TMO_W-1:0] r_cnt;

    always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
        if (!wbm_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Expiry is only meaningful while counting; the limit never exceeds the range.
    assign o_expire = i_en && (r_cnt == c_LIMIT);

endmodule : wb_tmo_cnt
`default_nettype wire

// File: rtl/wbm_arb2.sv
`default_nettype none
// ============================================================================
// Module      : wbm_arb2
// Description : Two-master round-robin Wishbone arbiter with access timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module wbm_arb2
    import wb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int BW      = 4,
    parameter int TMO_W   = 10,
    parameter int TMO_CYC = 1023
) (
    input  logic          wbm_clk_i,
    input  logic          wbm_rst_n,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    input  logic [BW-1:0] m0_sel_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    input  logic [BW-1:0] m1_sel_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic          wbd_cyc_o,
    output logic          wbd_stb_o,
    output logic          wbd_we_o,
    output logic [AW-1:0] wbd_adr_o,
    output logic [DW-1:0] wbd_dat_o,
    output logic [BW-1:0] wbd_sel_o,
    input  logic [DW-1:0] wbd_dat_i,
    input  logic          wbd_ack_i,
    input  logic          wbd_err_i,
    output logic [1:0]    gnt_o,
    output logic          tmo_pulse_o
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_gnt;
    logic [1:0] w_gnt_nxt;
    logic       r_last;        // 1 when master1 owned the last transfer
    logic       w_last_nxt;

    logic w_req0;
    logic w_req1;
    logic w_busy;
    logic w_sel_m1;
    logic w_own_req;
    logic w_abort;
    logic w_resp;
    logic w_expire;
    logic w_tmo;

    assign w_req0    = m0_cyc_i & m0_stb_i;
    assign w_req1    = m1_cyc_i & m1_stb_i;
    assign w_busy    = (r_state == BUSY);
    assign w_sel_m1  = r_gnt[1];
    assign w_own_req = w_sel_m1 ? w_req1 : w_req0;

    // A withdrawn request ends the access silently, even if a response races it.
    assign w_abort = w_busy & ~w_own_req;
    assign w_resp  = w_busy & w_own_req & (wbd_ack_i | wbd_err_i);
    assign w_tmo   = w_busy & w_own_req & ~(wbd_ack_i | wbd_err_i) & w_expire;

    wb_tmo_cnt #(
        .TMO_W   (TMO_W),
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .wbm_clk_i (wbm_clk_i),
        .wbm_rst_n (wbm_rst_n),
        .i_clr     (~w_busy),
        .i_en      (w_busy),
        .o_expire  (w_expire)
    );

    always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
        if (!wbm_rst_n) begin
            r_state <= IDLE;
            r_gnt   <= GNT_NONE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (w_req0 | w_req1) begin
                    w_state_nxt = BUSY;
                    if (w_req0 & w_req1) begin
                        w_gnt_nxt = r_last ? GNT_M0 : GNT_M1;
                    end else begin
                        w_gnt_nxt = w_req0 ? GNT_M0 : GNT_M1;
                    end
                end
            end
            BUSY: begin
                if (w_abort | w_resp | w_tmo) begin
                    w_state_nxt = GAP;
                    w_gnt_nxt   = GNT_NONE;
                    w_last_nxt  = w_sel_m1;
                end
            end
            GAP: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = GNT_NONE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = GNT_NONE;
            end
        endcase
    end

    always_comb begin
        wbd_cyc_o   = w_busy;
        wbd_stb_o   = w_busy;
        wbd_we_o    = 1'b0;
        wbd_adr_o   = '0;
        wbd_dat_o   = '0;
        wbd_sel_o   = '0;
        m0_ack_o    = 1'b0;
        m0_err_o    = 1'b0;
        m0_dat_o    = '0;
        m1_ack_o    = 1'b0;
        m1_err_o    = 1'b0;
        m1_dat_o    = '0;
        tmo_pulse_o = w_tmo;
        if (w_busy) begin
            wbd_we_o  = w_sel_m1 ? m1_we_i  : m0_we_i;
            wbd_adr_o = w_sel_m1 ? m1_adr_i : m0_adr_i;
            wbd_dat_o = w_sel_m1 ? m1_dat_i : m0_dat_i;
            wbd_sel_o = w_sel_m1 ? m1_sel_i : m0_sel_i;
        end
        if (w_sel_m1) begin
            m1_ack_o = w_resp & wbd_ack_i;
            m1_err_o = (w_resp & wbd_err_i) | w_tmo;
            m1_dat_o = w_resp ? wbd_dat_i : '0;
        end else begin
            m0_ack_o = w_resp & wbd_ack_i;
            m0_err_o = (w_resp & wbd_err_i) | w_tmo;
            m0_dat_o = w_resp ? wbd_dat_i : '0;
        end
    end

    assign gnt_o = r_gnt;

endmodule : wbm_arb2
`default_nettype wire
